// File: rtl/alu_power.sv
// alu_power: sequential signed base^exp, one multiply per clock, with start/busy/done handshake.
// Define POWER_SATURATE_EN to saturate the result on overflow instead of wrapping.
module alu_power #(
    parameter int WIDTH = 8,
    parameter int EXP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [EXP_W-1:0] exp,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             ovf
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_nx;
    logic signed [WIDTH-1:0]   base_r, acc;
    logic signed [2*WIDTH-1:0] prod;
    logic [EXP_W-1:0]          cnt;
    logic [WIDTH-1:0]          final_res;
    logic ovf_run, step_ovf, ovf_next, accept, last;

    assign prod     = acc * base_r;
    // the product fits WIDTH signed bits only if its top WIDTH+1 bits are a pure sign extension
    assign step_ovf = (prod[2*WIDTH-1:WIDTH-1] != '0) && (prod[2*WIDTH-1:WIDTH-1] != '1);
    assign ovf_next = ovf_run | step_ovf;
    assign accept   = start && (state != RUN);
    assign last     = (cnt == EXP_W'(1));
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

`ifdef POWER_SATURATE_EN
    logic odd;
    // acc has wrapped by now, so the true sign comes from the latched base and exponent parity
    assign final_res = ovf_next ? ((base_r[WIDTH-1] && odd) ? {1'b1, {(WIDTH-1){1'b0}}}
                                                            : {1'b0, {(WIDTH-1){1'b1}}})
                                : prod[WIDTH-1:0];
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            odd <= 1'b0;
        else if (accept)
            odd <= exp[0];
    end
`else
    assign final_res = prod[WIDTH-1:0];
`endif

    always_comb begin
        state_nx = state;
        if (accept)
            state_nx = (exp != '0) ? RUN : DONE;
        else if (state == DONE)
            state_nx = IDLE;
        else if (state == RUN && last)
            state_nx = DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            base_r  <= '0;
            acc     <= '0;
            cnt     <= '0;
            ovf_run <= 1'b0;
            result  <= '0;
            ovf     <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                base_r  <= base;
                acc     <= WIDTH'(1);
                cnt     <= exp;
                ovf_run <= 1'b0;
                ovf     <= 1'b0;
                if (exp == '0)
                    result <= WIDTH'(1);
            end else if (state == RUN) begin
                acc     <= prod[WIDTH-1:0];
                cnt     <= cnt - 1'b1;
                ovf_run <= ovf_next;
                if (last) begin
                    result <= final_res;
                    ovf    <= ovf_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_power.sv
// tb_alu_power: randomized and directed checks of alu_power against an integer reference model.
// Honours POWER_SATURATE_EN the same way as the design.
module tb_alu_power;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] base = '0;
    logic [3:0] exp = '0;
    logic [7:0] result;
    logic       busy, done, ovf;
    int errors = 0;
    int checks = 0;

    alu_power #(.WIDTH(8), .EXP_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .exp(exp),
        .result(result), .busy(busy), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // true power computed with clamped magnitude; wrapped value by mod-256 arithmetic
    function automatic void model(input int b, input int e, output logic [7:0] r, output logic o);
        logic [7:0] w;
        longint mag;
        bit neg;
        w = 8'd1;
        mag = 1;
        for (int i = 0; i < e; i++) begin
            w = w * 8'(b);
            mag = mag * ((b < 0) ? -b : b);
            if (mag > 1000) mag = 1000;
        end
        neg = (b < 0) && (e % 2 == 1);
        o = neg ? (mag > 128) : (mag > 127);
`ifdef POWER_SATURATE_EN
        r = o ? (neg ? 8'h80 : 8'h7f) : w;
`else
        r = w;
`endif
    endfunction

    // launch one op; returns edges from the accept edge (inclusive) to done, and busy cycles seen
    task automatic do_op(input int b, input int e, output int lat, output int nbusy);
        @(negedge clk);
        start = 1'b1;
        base = 8'(b);
        exp = 4'(e);
        nbusy = 0;
        @(posedge clk);
        lat = 1;
        #1;
        start = 1'b0;
        base = 8'($urandom);
        exp = 4'($urandom);
        @(negedge clk);
        while (!done && lat < 40) begin
            if (busy) nbusy++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks += 4;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        if (result !== 8'd0) begin errors++; $display("FAIL reset_result: got %0d want 0", result); end
        if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int lat, nb;
        do_op(3, 4, lat, nb);
        checks += 4;
        if (lat !== 5) begin errors++; $display("FAIL basic_latency: got %0d want 5", lat); end
        if (nb !== 4) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 4", nb); end
        if (result !== 8'd81) begin errors++; $display("FAIL basic_result: got %0d want 81", $signed(result)); end
        if (ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b want 0", ovf); end
        @(negedge clk);
        checks += 2;
        if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b want 0", done); end
        if (result !== 8'd81) begin errors++; $display("FAIL result_hold: got %0d want 81", $signed(result)); end
    endtask

    task automatic test_boundaries;
        int bs[4] = '{-2, 2, 5, -5};
        int es[4] = '{7, 7, 4, 0};
        int lat, nb;
        logic [7:0] r;
        logic o;
        for (int i = 0; i < 4; i++) begin
            do_op(bs[i], es[i], lat, nb);
            model(bs[i], es[i], r, o);
            checks += 4;
            if (result !== r) begin errors++; $display("FAIL bound_result %0d^%0d: got %0d want %0d", bs[i], es[i], $signed(result), $signed(r)); end
            if (ovf !== o) begin errors++; $display("FAIL bound_ovf %0d^%0d: got %b want %b", bs[i], es[i], ovf, o); end
            if (lat !== es[i] + 1) begin errors++; $display("FAIL bound_latency %0d^%0d: got %0d want %0d", bs[i], es[i], lat, es[i] + 1); end
            if (nb !== es[i]) begin errors++; $display("FAIL bound_busy %0d^%0d: got %0d want %0d", bs[i], es[i], nb, es[i]); end
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        @(negedge clk);
        start = 1'b1;
        base = 8'd3;
        exp = 4'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        base = 8'd7;
        exp = 4'd2;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks += 2;
        if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b want 1", done); end
        if (result !== 8'd81) begin errors++; $display("FAIL b2b_ignore_start: got %0d want 81", $signed(result)); end
        start = 1'b1;
        base = -8'sd3;
        exp = 4'd3;
        @(posedge clk);
        lat = 1;
        #1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_busy: got %b want 1", busy); end
        while (!done && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checks += 3;
        if (lat !== 4) begin errors++; $display("FAIL b2b_latency: got %0d want 4", lat); end
        if (result !== 8'hE5) begin errors++; $display("FAIL b2b_result: got %0d want -27", $signed(result)); end
        if (ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_async_reset;
        int lat, nb;
        @(negedge clk);
        start = 1'b1;
        base = 8'd2;
        exp = 4'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks += 4;
        if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL arst_done: got %b want 0", done); end
        if (result !== 8'd0) begin errors++; $display("FAIL arst_result: got %0d want 0", $signed(result)); end
        if (ovf !== 1'b0) begin errors++; $display("FAIL arst_ovf: got %b want 0", ovf); end
        @(negedge clk);
        rst = 1'b0;
        do_op(2, 5, lat, nb);
        checks += 2;
        if (result !== 8'd32) begin errors++; $display("FAIL arst_rerun_result: got %0d want 32", $signed(result)); end
        if (lat !== 6) begin errors++; $display("FAIL arst_rerun_latency: got %0d want 6", lat); end
    endtask

    task automatic test_sweep;
        int bs[5] = '{-128, -1, 0, 1, 127};
        int es[4] = '{0, 1, 2, 15};
        int lat, nb;
        logic [7:0] r;
        logic o;
        foreach (bs[i]) foreach (es[j]) begin
            do_op(bs[i], es[j], lat, nb);
            model(bs[i], es[j], r, o);
            checks += 3;
            if (result !== r) begin errors++; $display("FAIL sweep_result %0d^%0d: got %0d want %0d", bs[i], es[j], $signed(result), $signed(r)); end
            if (ovf !== o) begin errors++; $display("FAIL sweep_ovf %0d^%0d: got %b want %b", bs[i], es[j], ovf, o); end
            if (lat !== es[j] + 1) begin errors++; $display("FAIL sweep_latency %0d^%0d: got %0d want %0d", bs[i], es[j], lat, es[j] + 1); end
        end
    endtask

    task automatic test_random;
        int b, e, lat, nb;
        logic [7:0] r;
        logic o;
        for (int i = 0; i < 40; i++) begin
            b = $signed(8'($urandom));
            e = int'($urandom_range(0, 15));
            do_op(b, e, lat, nb);
            model(b, e, r, o);
            checks += 3;
            if (result !== r) begin errors++; $display("FAIL rand_result %0d^%0d: got %0d want %0d", b, e, $signed(result), $signed(r)); end
            if (ovf !== o) begin errors++; $display("FAIL rand_ovf %0d^%0d: got %b want %b", b, e, ovf, o); end
            if (lat !== e + 1) begin errors++; $display("FAIL rand_latency %0d^%0d: got %0d want %0d", b, e, lat, e + 1); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_back_to_back();
        test_async_reset();
        test_sweep();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
